// File: rtl/serial_link_credit_receiver_if.sv
// Packet-side and consumer-side signal bundle for serial_link_credit_receiver.
// The slave modport is the receiver's view. The master modport is the view of
// the environment, which drives the packet and ready inputs.
interface serial_link_credit_receiver_if #(
  parameter int DataWidth   = 32,
  parameter int CreditWidth = 4
);
  logic                   pkt_valid_i;
  logic                   pkt_ready_o;
  logic                   pkt_credit_only_i;
  logic [DataWidth-1:0]   pkt_data_i;
  logic [CreditWidth-1:0] pkt_credits_i;
  logic [CreditWidth-1:0] credits_received_o;
  logic                   data_valid_o;
  logic                   data_ready_i;
  logic [DataWidth-1:0]   data_o;
  logic [1:0]             credit_free_o;
  logic [CreditWidth-1:0] fill_o;
  logic                   overflow_o;

  modport slave (
    input  pkt_valid_i, pkt_credit_only_i, pkt_data_i, pkt_credits_i, data_ready_i,
    output pkt_ready_o, credits_received_o, data_valid_o, data_o, credit_free_o,
           fill_o, overflow_o
  );

  modport master (
    output pkt_valid_i, pkt_credit_only_i, pkt_data_i, pkt_credits_i, data_ready_i,
    input  pkt_ready_o, credits_received_o, data_valid_o, data_o, credit_free_o,
           fill_o, overflow_o
  );
endinterface

// File: rtl/serial_link_credit_receiver.sv
// Receive side of the serial credit link. The receiver takes every packet and
// registers the piggy-backed credits. It buffers normal packets in a circular
// FIFO of NumCredits entries and reports each freed receive buffer on
// credit_free_o.
// Optional feature: define SERIAL_LINK_RX_FALLTHROUGH_EN to let a packet that
// arrives at an empty FIFO appear on data_o in the same cycle.
module serial_link_credit_receiver #(
  parameter int DataWidth   = 32,
  parameter int NumCredits  = 8,
  parameter int CreditWidth = $clog2(NumCredits + 1)
) (
  input logic clk_i,
  input logic rst_i,
  serial_link_credit_receiver_if.slave link
);

  localparam int PtrWidth = (NumCredits > 1) ? $clog2(NumCredits) : 1;
  localparam logic [CreditWidth-1:0] FullLevel = CreditWidth'(NumCredits);
  localparam logic [PtrWidth-1:0]    LastPtr   = PtrWidth'(NumCredits - 1);

  logic [DataWidth-1:0]   mem_r [NumCredits];
  logic [PtrWidth-1:0]    rd_ptr_r;
  logic [PtrWidth-1:0]    wr_ptr_r;
  logic [CreditWidth-1:0] fill_r;
  logic                   overflow_r;
  logic [CreditWidth-1:0] credits_r;
  logic                   co_release_r;

  logic                   normal_pkt_s;
  logic                   empty_s;
  logic                   full_s;
  logic                   bypass_s;
  logic                   pop_mem_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   drop_s;
  logic                   data_valid_s;
  logic [DataWidth-1:0]   head_s;

  // Pointer advance with wrap at NumCredits, which need not be a power of two.
  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
    if (ptr == LastPtr) begin
      return '0;
    end else begin
      return ptr + 1'b1;
    end
  endfunction

  // Decide push, pop, bypass and drop for this cycle.
  always_comb begin
    normal_pkt_s = link.pkt_valid_i & ~link.pkt_credit_only_i;
    empty_s      = (fill_r == '0);
    full_s       = (fill_r == FullLevel);
    pop_mem_s    = ~empty_s & link.data_ready_i;
`ifdef SERIAL_LINK_RX_FALLTHROUGH_EN
    bypass_s     = normal_pkt_s & empty_s & link.data_ready_i;
    data_valid_s = ~empty_s | normal_pkt_s;
    if (!empty_s) begin
      head_s = mem_r[rd_ptr_r];
    end else if (normal_pkt_s) begin
      head_s = link.pkt_data_i;
    end else begin
      head_s = '0;
    end
`else
    bypass_s     = 1'b0;
    data_valid_s = ~empty_s;
    if (!empty_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = '0;
    end
`endif
    pop_s  = data_valid_s & link.data_ready_i;
    // A pop from a full FIFO frees the slot that the incoming packet needs.
    push_s = normal_pkt_s & ~bypass_s & (~full_s | pop_mem_s);
    drop_s = normal_pkt_s & full_s & ~pop_mem_s;
  end

  // Pointers, occupancy, sticky overflow and the registered credit stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      fill_r       <= '0;
      overflow_r   <= 1'b0;
      credits_r    <= '0;
      co_release_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop_mem_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_s, pop_mem_s})
        2'b10:   fill_r <= fill_r + 1'b1;
        2'b01:   fill_r <= fill_r - 1'b1;
        default: fill_r <= fill_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      credits_r    <= link.pkt_valid_i ? link.pkt_credits_i : '0;
      co_release_r <= link.pkt_valid_i & link.pkt_credit_only_i;
    end
  end

  // Payload storage. It is not reset because data_o is gated while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= link.pkt_data_i;
    end
  end

  assign link.pkt_ready_o        = 1'b1;
  assign link.credits_received_o = credits_r;
  assign link.data_valid_o       = data_valid_s;
  assign link.data_o             = head_s;
  assign link.credit_free_o      = {1'b0, pop_s} + {1'b0, co_release_r};
  assign link.fill_o             = fill_r;
  assign link.overflow_o         = overflow_r;

endmodule

// File: tb/tb_serial_link_credit_receiver.sv
// Self-checking bench for serial_link_credit_receiver. A queue-based model of
// the receive buffer predicts every output in every cycle. Directed scenarios
// run first, followed by a randomized traffic phase.
module tb_serial_link_credit_receiver;
  localparam int DataWidth   = 32;
  localparam int NumCredits  = 8;
  localparam int CreditWidth = $clog2(NumCredits + 1);
`ifdef SERIAL_LINK_RX_FALLTHROUGH_EN
  localparam bit FallThrough = 1'b1;
`else
  localparam bit FallThrough = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   num_checks = 0;
  int   num_fails  = 0;

  serial_link_credit_receiver_if #(.DataWidth(DataWidth), .CreditWidth(CreditWidth)) link_if ();

  serial_link_credit_receiver #(
    .DataWidth(DataWidth), .NumCredits(NumCredits), .CreditWidth(CreditWidth)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .link  (link_if.slave)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [DataWidth-1:0]   model_q[$];
  logic                   model_ov;
  logic [CreditWidth-1:0] model_last_cr;
  logic                   model_last_co;

  task automatic chk_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic drive(input logic v, input logic co, input logic [DataWidth-1:0] d,
                       input logic [CreditWidth-1:0] cr, input logic rdy);
    link_if.pkt_valid_i       = v;
    link_if.pkt_credit_only_i = co;
    link_if.pkt_data_i        = d;
    link_if.pkt_credits_i     = cr;
    link_if.data_ready_i      = rdy;
  endtask

  task automatic model_reset();
    model_q.delete();
    model_ov      = 1'b0;
    model_last_cr = '0;
    model_last_co = 1'b0;
  endtask

  function automatic logic exp_valid();
    logic normal;
    normal = link_if.pkt_valid_i & ~link_if.pkt_credit_only_i;
    return (model_q.size() != 0) || (FallThrough && normal);
  endfunction

  // Compare all outputs against the model at the falling edge.
  task automatic check_cycle();
    logic                 dv;
    logic [DataWidth-1:0] dexp;
    int                   pop;
    @(negedge clk);
    dv = exp_valid();
    if (model_q.size() != 0) begin
      dexp = model_q[0];
    end else if (dv) begin
      dexp = link_if.pkt_data_i;
    end else begin
      dexp = '0;
    end
    pop = (dv && link_if.data_ready_i) ? 1 : 0;
    chk_eq("pkt_ready", 64'(link_if.pkt_ready_o), 64'd1);
    chk_eq("data_valid", 64'(link_if.data_valid_o), 64'(dv));
    chk_eq("data", 64'(link_if.data_o), 64'(dexp));
    chk_eq("credit_free", 64'(link_if.credit_free_o), 64'(pop + int'(model_last_co)));
    chk_eq("fill", 64'(link_if.fill_o), 64'(model_q.size()));
    chk_eq("overflow", 64'(link_if.overflow_o), 64'(model_ov));
    chk_eq("credits_received", 64'(link_if.credits_received_o), 64'(model_last_cr));
  endtask

  // Advance the model across the rising edge.
  task automatic commit_cycle();
    logic dv;
    logic normal;
    logic consumed;
    dv       = exp_valid();
    normal   = link_if.pkt_valid_i & ~link_if.pkt_credit_only_i;
    consumed = 1'b0;
    @(posedge clk);
    if (dv && link_if.data_ready_i) begin
      if (model_q.size() != 0) begin
        void'(model_q.pop_front());
      end else begin
        consumed = 1'b1;
      end
    end
    if (normal && !consumed) begin
      if (model_q.size() < NumCredits) begin
        model_q.push_back(link_if.pkt_data_i);
      end else begin
        model_ov = 1'b1;
      end
    end
    model_last_cr = link_if.pkt_valid_i ? link_if.pkt_credits_i : '0;
    model_last_co = link_if.pkt_valid_i & link_if.pkt_credit_only_i;
    #1;
  endtask

  task automatic run_cycle();
    check_cycle();
    commit_cycle();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    apply_reset();

    // Idle after reset: every output holds its reset value.
    repeat (5) run_cycle();

    // Credit-only packet carrying 3 credits.
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 4'd3, 1'b0);
    run_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    check_cycle();
    chk_eq("co_credits", 64'(link_if.credits_received_o), 64'd3);
    chk_eq("co_free", 64'(link_if.credit_free_o), 64'd1);
    chk_eq("co_fill", 64'(link_if.fill_o), 64'd0);
    commit_cycle();

    // Fill the FIFO with 0xA0..0xA7 while the consumer stalls.
    for (int i = 0; i < NumCredits; i++) begin
      drive(1'b1, 1'b0, 32'hA0 + 32'(i), 4'd0, 1'b0);
      run_cycle();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    check_cycle();
    chk_eq("full_fill", 64'(link_if.fill_o), 64'd8);
    chk_eq("full_no_ov", 64'(link_if.overflow_o), 64'd0);
    commit_cycle();

    // Push and pop together while full.
    drive(1'b1, 1'b0, 32'hA8, 4'd0, 1'b1);
    check_cycle();
    chk_eq("pp_head", 64'(link_if.data_o), 64'hA0);
    commit_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    check_cycle();
    chk_eq("pp_fill", 64'(link_if.fill_o), 64'd8);
    chk_eq("pp_no_ov", 64'(link_if.overflow_o), 64'd0);
    commit_cycle();

    // Push into the full FIFO with no pop: the packet is dropped and the flag sticks.
    drive(1'b1, 1'b0, 32'hBB, 4'd5, 1'b0);
    run_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    check_cycle();
    chk_eq("ov_set", 64'(link_if.overflow_o), 64'd1);
    chk_eq("ov_credits", 64'(link_if.credits_received_o), 64'd5);
    commit_cycle();
    for (int i = 0; i < NumCredits; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      check_cycle();
      chk_eq("drain_order", 64'(link_if.data_o), 64'hA1 + 64'(i));
      commit_cycle();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    check_cycle();
    chk_eq("drain_empty", 64'(link_if.fill_o), 64'd0);
    chk_eq("ov_sticky", 64'(link_if.overflow_o), 64'd1);
    commit_cycle();

    // A credit-only release and a pop land in the same cycle.
    drive(1'b1, 1'b0, 32'h11, 4'd0, 1'b0);
    run_cycle();
    drive(1'b1, 1'b1, '0, 4'd2, 1'b0);
    run_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    check_cycle();
    chk_eq("free_two", 64'(link_if.credit_free_o), 64'd2);
    commit_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    run_cycle();

    // Normal packet arriving at an empty FIFO with the consumer ready.
    drive(1'b1, 1'b0, 32'h55, 4'd0, 1'b1);
    check_cycle();
`ifdef SERIAL_LINK_RX_FALLTHROUGH_EN
    chk_eq("ft_data", 64'(link_if.data_o), 64'h55);
    chk_eq("ft_free", 64'(link_if.credit_free_o), 64'd1);
`else
    chk_eq("nft_valid_late", 64'(link_if.data_valid_o), 64'd0);
`endif
    commit_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    check_cycle();
`ifdef SERIAL_LINK_RX_FALLTHROUGH_EN
    chk_eq("ft_fill", 64'(link_if.fill_o), 64'd0);
`else
    chk_eq("nft_valid_next", 64'(link_if.data_valid_o), 64'd1);
`endif
    commit_cycle();

    // Randomized traffic. The ready bias changes per block so the FIFO both fills and drains.
    apply_reset();
    for (int blk = 0; blk < 12; blk++) begin
      int ready_pct;
      ready_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 60 : 95);
      for (int c = 0; c < 50; c++) begin
        drive(($urandom_range(99) < 70), ($urandom_range(99) < 25), 32'($urandom),
              CreditWidth'($urandom_range(NumCredits)), ($urandom_range(99) < ready_pct));
        run_cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end
endmodule
